// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches from a PC, keeps a 2-entry in-order response
// buffer and flushes/drops in-flight data on redirect. Macro FETCH_MISALIGN_TRAP_EN adds the trap.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] redirect_addr,
    input  logic        redirect_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    input  logic        inst_ready,
    output logic        fetch_fault
);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] rpc_q, rpc_d;
    logic [1:0]  outstanding_q, outstanding_d;
    logic [1:0]  drop_q, drop_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] buf0_pc_q, buf0_pc_d, buf0_data_q, buf0_data_d;
    logic [31:0] buf1_pc_q, buf1_pc_d, buf1_data_q, buf1_data_d;

    logic [31:0] target;
    logic        misaligned;
    logic        grant;
    logic        resp;
    logic        dropping;
    logic        push;
    logic        pop;
    logic        wr_slot;
    logic [2:0]  occupancy;

    // Redirect targets are always word aligned on the fetch side.
    assign target = redirect_addr & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q, fault_d;

    assign misaligned  = redirect_en && (redirect_addr[1:0] != 2'b00);
    assign fetch_fault = fault_q;

    always_comb begin
        fault_d = fault_q;
        if (misaligned) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    assign misaligned  = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    assign inst_valid = (count_q != 2'd0);
    assign inst_pc    = buf0_pc_q;
    assign inst_data  = buf0_data_q;
    assign imem_addr  = fpc_q;

    assign pop      = inst_valid && inst_ready;
    // Responses with nothing outstanding (stale, pre-reset) are ignored.
    assign resp     = imem_rvalid && (outstanding_q != 2'd0);
    assign dropping = (drop_q != 2'd0);
    assign push     = resp && !dropping && !redirect_en;

    // A pop this cycle frees a slot before any response to a new request can arrive.
    assign occupancy = {1'b0, outstanding_q} + {1'b0, count_q} - {2'b00, pop};

    assign imem_req = !reset && (state_q == StRun) && !redirect_en && (occupancy < 3'd2);
    assign grant    = imem_req && imem_gnt;

    always_comb begin
        state_d = state_q;
        if (misaligned) begin
            state_d = StHalt;
        end
    end

    always_comb begin
        fpc_d         = fpc_q;
        rpc_d         = rpc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;

        unique case ({grant, resp})
            2'b10:   outstanding_d = outstanding_q + 2'd1;
            2'b01:   outstanding_d = outstanding_q - 2'd1;
            default: outstanding_d = outstanding_q;
        endcase

        if (redirect_en) begin
            fpc_d  = target;
            rpc_d  = target;
            drop_d = outstanding_q - {1'b0, resp};
        end else begin
            if (grant) begin
                fpc_d = fpc_q + 32'd4;
            end
            // Non-dropped responses are sequential from the last redirect target.
            if (push) begin
                rpc_d = rpc_q + 32'd4;
            end
            if (resp && dropping) begin
                drop_d = drop_q - 2'd1;
            end
        end
    end

    always_comb begin
        count_d     = count_q;
        buf0_pc_d   = buf0_pc_q;
        buf0_data_d = buf0_data_q;
        buf1_pc_d   = buf1_pc_q;
        buf1_data_d = buf1_data_q;
        wr_slot     = pop ? (count_q == 2'd2) : (count_q != 2'd0);

        if (redirect_en) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                buf0_pc_d   = buf1_pc_q;
                buf0_data_d = buf1_data_q;
            end
            if (push) begin
                if (wr_slot) begin
                    buf1_pc_d   = rpc_q;
                    buf1_data_d = imem_rdata;
                end else begin
                    buf0_pc_d   = rpc_q;
                    buf0_data_d = imem_rdata;
                end
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StRun;
            fpc_q         <= RESET_PC;
            rpc_q         <= RESET_PC;
            outstanding_q <= 2'd0;
            drop_q        <= 2'd0;
            count_q       <= 2'd0;
        end else begin
            state_q       <= state_d;
            fpc_q         <= fpc_d;
            rpc_q         <= rpc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
        end
    end

    // Buffer payload is qualified by count_q, so it needs no reset.
    always_ff @(posedge clk) begin
        buf0_pc_q   <= buf0_pc_d;
        buf0_data_q <= buf0_data_d;
        buf1_pc_q   <= buf1_pc_d;
        buf1_data_q <= buf1_data_d;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order randomized memory responder plus a model of the expected
// delivered PC stream (sequential from reset PC or last redirect target), with directed steps.
`timescale 1ns/1ps
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] redirect_addr;
    logic        redirect_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        inst_ready;
    logic        fetch_fault;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .redirect_addr(redirect_addr),
        .redirect_en  (redirect_en),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst_pc      (inst_pc),
        .inst_data    (inst_data),
        .inst_ready   (inst_ready),
        .fetch_fault  (fetch_fault)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mem_q[$];
    logic [31:0] pop_log[$];
    int          gnt_pct = 100;
    int          rv_pct  = 100;
    int          rdy_pct = 100;
    logic [31:0] data_key = 32'h0;
    logic [31:0] exp_pc;
    bit          prev_pending;
    logic [31:0] prev_addr;
    bit          expect_valid_low;
    logic        obs_req, obs_valid, obs_fault, obs_rvalid;
    logic [31:0] obs_addr, obs_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, observe 1ns later, update models.
    task automatic step(input bit redir, input logic [31:0] tgt);
        redirect_en   = redir;
        redirect_addr = tgt;
        imem_gnt      = ($urandom_range(99) < gnt_pct);
        inst_ready    = ($urandom_range(99) < rdy_pct);
        if (mem_q.size() != 0 && $urandom_range(99) < rv_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q[0] ^ data_key;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        obs_req    = imem_req;
        obs_addr   = imem_addr;
        obs_valid  = inst_valid;
        obs_pc     = inst_pc;
        obs_fault  = fetch_fault;
        obs_rvalid = imem_rvalid;
        if (reset) begin
            check("req_during_reset", imem_req, 32'd0);
            mem_q.delete();
            exp_pc           = RESET_PC;
            prev_pending     = 1'b0;
            expect_valid_low = 1'b0;
        end else begin
            if (expect_valid_low) check("valid_after_redirect", inst_valid, 32'd0);
            if (redir) check("req_low_on_redirect", imem_req, 32'd0);
            if (prev_pending && !redir) begin
                check("pending_req_held", imem_req, 32'd1);
                check("pending_addr_held", imem_addr, prev_addr);
            end
            if (inst_valid && inst_ready) begin
                check("inst_pc", inst_pc, exp_pc);
                check("inst_data", inst_data, exp_pc ^ data_key);
                pop_log.push_back(inst_pc);
                exp_pc = exp_pc + 32'd4;
            end
            if (redir) exp_pc = tgt & 32'hFFFF_FFFC;
            expect_valid_low = redir;
            if (imem_rvalid) void'(mem_q.pop_front());
            if (imem_req && imem_gnt) mem_q.push_back(imem_addr);
            prev_pending = imem_req && !imem_gnt;
            prev_addr    = imem_addr;
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        bit          found;
        logic [31:0] tgt;

        reset         = 1'b1;
        redirect_en   = 1'b0;
        redirect_addr = 32'h0;
        imem_gnt      = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'h0;
        inst_ready    = 1'b0;
        exp_pc        = RESET_PC;
        prev_pending  = 1'b0;
        prev_addr     = 32'h0;
        expect_valid_low = 1'b0;
        @(negedge clk);
        repeat (3) step(1'b0, 32'h0);
        reset = 1'b0;

        // Zero-wait memory, decode always ready: one instruction per cycle from cycle 2.
        step(1'b0, 32'h0);
        check("first_req", obs_req, 32'd1);
        check("first_addr", obs_addr, RESET_PC);
        check("valid_after_reset", obs_valid, 32'd0);
        check("fault_after_reset", obs_fault, 32'd0);
        step(1'b0, 32'h0);
        check("valid_cycle1", obs_valid, 32'd0);
        step(1'b0, 32'h0);
        check("valid_cycle2", obs_valid, 32'd1);
        check("pc_cycle2", obs_pc, RESET_PC);
        n = 0;
        repeat (12) begin
            step(1'b0, 32'h0);
            if (obs_valid) n++;
        end
        check("one_per_cycle", n, 32'd12);

        // Decode stalls: buffer fills to exactly two entries and requests stop.
        rdy_pct = 0;
        repeat (10) step(1'b0, 32'h0);
        check("stall_valid", obs_valid, 32'd1);
        check("stall_no_req", obs_req, 32'd0);
        gnt_pct = 0;
        rdy_pct = 100;
        n = 0;
        repeat (4) begin
            step(1'b0, 32'h0);
            if (obs_valid) n++;
        end
        check("buffered_entries", n, 32'd2);
        gnt_pct = 100;

        // Two requests outstanding at redirect: both responses dropped.
        rv_pct = 0;
        repeat (3) step(1'b0, 32'h0);
        step(1'b1, 32'h0000_0100);
        rv_pct = 100;
        found = 1'b0;
        repeat (10) if (!found) begin
            step(1'b0, 32'h0);
            if (obs_valid) begin
                found = 1'b1;
                check("pc_after_drop", obs_pc, 32'h0000_0100);
            end
        end
        check("drop_redirect_delivers", found, 32'd1);

        // Redirect coincident with grant and an arriving response.
        repeat (4) step(1'b0, 32'h0);
        step(1'b1, 32'h0000_0200);
        check("redirect_saw_rvalid", obs_rvalid, 32'd1);
        step(1'b0, 32'h0);
        check("target_req_next", obs_req, 32'd1);
        check("target_addr_next", obs_addr, 32'h0000_0200);
        step(1'b0, 32'h0);
        check("target_valid_r2", obs_valid, 32'd0);
        step(1'b0, 32'h0);
        check("target_valid_r3", obs_valid, 32'd1);
        check("target_pc_r3", obs_pc, 32'h0000_0200);

        // Address wrap at the top of memory.
        step(1'b1, 32'hFFFF_FFF8);
        pop_log.delete();
        repeat (6) step(1'b0, 32'h0);
        check("wrap_count_ok", (pop_log.size() >= 3), 32'd1);
        if (pop_log.size() >= 3) begin
            check("wrap_pc0", pop_log[0], 32'hFFFF_FFF8);
            check("wrap_pc1", pop_log[1], 32'hFFFF_FFFC);
            check("wrap_pc2", pop_log[2], 32'h0000_0000);
        end

        // Misaligned redirect.
        step(1'b1, 32'h0000_0102);
`ifdef FETCH_MISALIGN_TRAP_EN
        step(1'b0, 32'h0);
        check("fault_set", obs_fault, 32'd1);
        check("halt_no_req", obs_req, 32'd0);
        n = 0;
        repeat (8) begin
            step(1'b0, 32'h0);
            if (obs_req) n++;
        end
        check("halt_req_count", n, 32'd0);
        check("fault_sticky", obs_fault, 32'd1);
        check("halt_valid_low", obs_valid, 32'd0);
        reset = 1'b1;
        repeat (2) step(1'b0, 32'h0);
        reset = 1'b0;
        step(1'b0, 32'h0);
        check("fault_cleared", obs_fault, 32'd0);
        check("req_after_halt_reset", obs_req, 32'd1);
`else
        found = 1'b0;
        repeat (10) if (!found) begin
            step(1'b0, 32'h0);
            if (obs_valid) begin
                found = 1'b1;
                check("misalign_forced_pc", obs_pc, 32'h0000_0100);
            end
        end
        check("misalign_delivers", found, 32'd1);
        check("fault_tied_low", obs_fault, 32'd0);
`endif

        // Randomized traffic with a fresh data scramble key.
        reset = 1'b1;
        repeat (2) step(1'b0, 32'h0);
        data_key = $urandom;
        reset    = 1'b0;
        gnt_pct  = 70;
        rv_pct   = 60;
        rdy_pct  = 70;
        pop_log.delete();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 4) begin
                tgt = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
                tgt[1:0] = 2'b00;
`endif
                step(1'b1, tgt);
            end else begin
                step(1'b0, 32'h0);
            end
        end
        check("random_progress", (pop_log.size() > 200), 32'd1);

        // Reset in the middle of traffic discards everything.
        reset = 1'b1;
        step(1'b0, 32'h0);
        reset = 1'b0;
        step(1'b0, 32'h0);
        check("midreset_valid", obs_valid, 32'd0);
        check("midreset_req", obs_req, 32'd1);
        check("midreset_addr", obs_addr, RESET_PC);
        repeat (20) step(1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
